// File: rtl/multi_channel_dds.sv
// Time-multiplexed multi-channel DDS: per-channel phase accumulators share one sine ROM
// through a three-stage pipeline (address, ROM read, gain shift).
module multi_channel_dds #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned FPBITS        = 16,
    parameter int unsigned ROM_ADDR_BITS = 10,
    parameter int unsigned OUT_WIDTH     = 16,
    localparam int unsigned ACC_WIDTH    = FPBITS + ROM_ADDR_BITS,
    localparam int unsigned CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_chan,
    input  logic [ACC_WIDTH-1:0] cfg_step,
    input  logic [ACC_WIDTH-1:0] cfg_phase,
    input  logic [3:0]           cfg_gain,
    input  logic                 cfg_clear,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic [CW-1:0]        sample_chan,
    output logic                 sample_valid,
    output logic                 frame_end
);
    localparam int unsigned ROM_DEPTH = 2 ** ROM_ADDR_BITS;

    logic [ACC_WIDTH-1:0] acc_q   [CHANNELS];
    logic [ACC_WIDTH-1:0] step_q  [CHANNELS];
    logic [ACC_WIDTH-1:0] phase_q [CHANNELS];
    logic [3:0]           gain_q  [CHANNELS];
    logic [CW-1:0]        slot_q;

    logic                     s1_valid;
    logic [ROM_ADDR_BITS-1:0] s1_addr;
    logic [CW-1:0]            s1_chan;
    logic [3:0]               s1_gain;
    logic                     s2_valid;
    logic signed [OUT_WIDTH-1:0] s2_word;
    logic [CW-1:0]            s2_chan;
    logic [3:0]               s2_gain;

    logic signed [OUT_WIDTH-1:0] rom [ROM_DEPTH];
    logic [ROM_ADDR_BITS-1:0]    slot_addr;

    // Elaboration-time sine table, rounded to nearest.
    function automatic logic signed [OUT_WIDTH-1:0] sine_entry(input int k);
        real amp;
        real ang;
        amp = real'((longint'(1) << (OUT_WIDTH - 1)) - 1);
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(ROM_DEPTH);
        return OUT_WIDTH'(longint'(amp * $sin(ang)));
    endfunction

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        assign rom[k] = sine_entry(k);
    end

    // Address uses the pre-update accumulator of the current slot.
    always_comb begin
        slot_addr = ROM_ADDR_BITS'((acc_q[slot_q] + phase_q[slot_q]) >> FPBITS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                acc_q[c]   <= '0;
                step_q[c]  <= '0;
                phase_q[c] <= '0;
                gain_q[c]  <= '0;
            end
            slot_q <= '0;
        end else begin
            if (enable) begin
                slot_q <= (slot_q == CW'(CHANNELS - 1)) ? '0 : slot_q + 1'b1;
            end
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (enable && slot_q == CW'(c)) begin
                    acc_q[c] <= acc_q[c] + step_q[c];
                end
                // Later assignment lets a clear override the slot's accumulator update.
                if (cfg_we && cfg_chan == CW'(c)) begin
                    step_q[c]  <= cfg_step;
                    phase_q[c] <= cfg_phase;
                    gain_q[c]  <= cfg_gain;
                    if (cfg_clear) begin
                        acc_q[c] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_addr      <= '0;
            s1_chan      <= '0;
            s1_gain      <= '0;
            s2_valid     <= 1'b0;
            s2_word      <= '0;
            s2_chan      <= '0;
            s2_gain      <= '0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
            sample_chan  <= '0;
            frame_end    <= 1'b0;
        end else begin
            s1_valid <= enable;
            if (enable) begin
                s1_addr <= slot_addr;
                s1_chan <= slot_q;
                s1_gain <= gain_q[slot_q];
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= rom[s1_addr];
                s2_chan <= s1_chan;
                s2_gain <= s1_gain;
            end
            sample_valid <= s2_valid;
            frame_end    <= s2_valid && (s2_chan == CW'(CHANNELS - 1));
            if (s2_valid) begin
                sample_out  <= s2_word >>> s2_gain;
                sample_chan <= s2_chan;
            end
        end
    end
endmodule

// File: tb/tb_multi_channel_dds.sv
// Directed bench for multi_channel_dds with a timed scoreboard model of the channel rules.
module tb_multi_channel_dds;
    localparam int CH = 4;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_chan = '0;
    logic [AW-1:0] cfg_step = '0;
    logic [AW-1:0] cfg_phase = '0;
    logic [3:0]    cfg_gain = '0;
    logic          cfg_clear = 1'b0;
    logic [15:0]   sample_out;
    logic [1:0]    sample_chan;
    logic          sample_valid;
    logic          frame_end;

    multi_channel_dds dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_chan     (cfg_chan),
        .cfg_step     (cfg_step),
        .cfg_phase    (cfg_phase),
        .cfg_gain     (cfg_gain),
        .cfg_clear    (cfg_clear),
        .sample_out   (sample_out),
        .sample_chan  (sample_chan),
        .sample_valid (sample_valid),
        .frame_end    (frame_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int chan;
        int val;
    } exp_t;

    exp_t          q[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            ecount = 0;
    bit            started = 0;
    int            test_id = 0;
    int            ch0_cnt = 0;
    logic [AW-1:0] m_acc[CH];
    logic [AW-1:0] m_step[CH];
    logic [AW-1:0] m_phase[CH];
    int            m_gain[CH];
    int            m_slot;

    function automatic int rom_model(int k);
        real x;
        x = 32767.0 * $sin(2.0 * 3.141592653589793 * k / 1024.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: apply the channel rules at each rising edge and schedule the expected sample.
    always @(posedge clk) begin : model
        logic [AW-1:0] a;
        int s;
        int v;
        ecount++;
        if (reset) begin
            q.delete();
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = '0; m_step[c] = '0; m_phase[c] = '0; m_gain[c] = 0;
            end
            m_slot = 0;
        end else begin
            if (enable) begin
                s = m_slot;
                a = m_acc[s] + m_phase[s];
                v = rom_model(int'(a >> 16)) >>> m_gain[s];
                q.push_back('{ecount + 2, s, v});
                m_acc[s] = m_acc[s] + m_step[s];
                m_slot = (m_slot + 1) % CH;
            end
            if (cfg_we && int'(cfg_chan) < CH) begin
                m_step[cfg_chan]  = cfg_step;
                m_phase[cfg_chan] = cfg_phase;
                m_gain[cfg_chan]  = int'(cfg_gain);
                if (cfg_clear) m_acc[cfg_chan] = '0;
            end
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        bit ev;
        longint so;
        if (started) begin
            ev = (q.size() > 0) && (q[0].due == ecount);
            e = '{0, 0, 0};
            if (ev) e = q.pop_front();
            so = longint'($signed(sample_out));
            check("sample_valid", longint'(sample_valid), longint'(ev));
            check("frame_end", longint'(frame_end), longint'(ev && e.chan == CH - 1));
            if (ev) begin
                check("sample_chan", longint'(sample_chan), longint'(e.chan));
                check("sample_out", so, longint'(e.val));
                if (e.chan == 0) ch0_cnt++;
                if (test_id == 2 && e.chan == 0 && ch0_cnt == 257) check("rom256_peak", so, 32767);
                if (test_id == 2 && e.chan == 0 && ch0_cnt == 769) check("rom768_trough", so, -32767);
                if (test_id == 3 && e.chan == 1) check("gain2_sample", so, 8191);
                if (test_id == 4 && e.chan == 0 && ch0_cnt == 2) check("wrap_addr1023", so, -201);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        started = 1;
        check("reset_sample_out", longint'(sample_out), 0);
        check("reset_sample_chan", longint'(sample_chan), 0);
        reset = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_clear = 1'b0;
    endtask

    task automatic set_cfg(int ch, logic [AW-1:0] st, logic [AW-1:0] ph, int g, bit clr);
        cfg_we = 1'b1; cfg_chan = 2'(ch); cfg_step = st; cfg_phase = ph;
        cfg_gain = 4'(g); cfg_clear = clr;
    endtask

    initial begin
        check("model_rom0", rom_model(0), 0);
        check("model_rom1", rom_model(1), 201);
        check("model_rom256", rom_model(256), 32767);
        check("model_rom768", rom_model(768), -32767);

        // All-zero config: channels 0..3 cycling, zero samples.
        test_id = 1;
        tick();
        do_reset();
        enable = 1'b1;
        repeat (20) tick();

        // Channel 0 sweeping the table one entry per sample.
        do_reset();
        test_id = 2; ch0_cnt = 0;
        set_cfg(0, 26'h0010000, '0, 0, 0); tick(); cfg_we = 1'b0;
        enable = 1'b1;
        repeat (770 * 4 + 4) tick();

        // Channel 1 fixed at quarter phase, attenuated by 4; enable bubbles included.
        do_reset();
        test_id = 3;
        set_cfg(1, '0, 26'h1000000, 2, 0); tick(); cfg_we = 1'b0;
        enable = 1'b1;
        repeat (10) tick();
        enable = 1'b0; repeat (3) tick();
        enable = 1'b1; repeat (5) tick();
        enable = 1'b0; tick();
        enable = 1'b1; repeat (12) tick();

        // Channel 0 stepping backwards by one LSB: accumulator wraps through zero.
        do_reset();
        test_id = 4; ch0_cnt = 0;
        set_cfg(0, 26'h3FFFFFF, '0, 0, 0); tick(); cfg_we = 1'b0;
        enable = 1'b1;
        repeat (20) tick();

        // Reconfigure and clear channel 2 in its own slot cycle.
        do_reset();
        test_id = 5;
        set_cfg(2, 26'h0010000, 26'h0004000, 0, 0); tick(); cfg_we = 1'b0;
        enable = 1'b1;
        tick(); tick();
        set_cfg(2, 26'h0020000, 26'h0040000, 1, 0); tick(); cfg_we = 1'b0;
        repeat (3) tick();
        set_cfg(2, 26'h0030000, 26'h0000000, 3, 1); tick(); cfg_we = 1'b0;
        repeat (3) tick();
        set_cfg(0, 26'h0050000, 26'h0100000, 1, 0); tick(); cfg_we = 1'b0;
        repeat (16) tick();

        // Reset with samples in flight while enable and cfg_we are high.
        do_reset();
        test_id = 6;
        set_cfg(0, 26'h0100000, 26'h0020000, 0, 0); tick(); cfg_we = 1'b0;
        enable = 1'b1;
        repeat (9) tick();
        set_cfg(3, 26'h0200000, 26'h0300000, 1, 0);
        do_reset();
        repeat (3) tick();
        enable = 1'b1;
        repeat (10) tick();
        enable = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/multi_channel_dds.md
MULTI_CHANNEL_DDS -- requirements
Module: multi_channel_dds

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, number of time-multiplexed tone channels (power of 2, 1..16).
REQ-002 SHALL provide parameter FPBITS, default 16, fractional bits of each phase accumulator.
REQ-003 SHALL provide parameter ROM_ADDR_BITS, default 10, log2 of sine table depth.
REQ-004 SHALL provide parameter OUT_WIDTH, default 16, signed sample width.
REQ-005 SHALL derive ACC_WIDTH = FPBITS + ROM_ADDR_BITS, default 26.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 enable  input  1  high: one channel slot processed this cycle.
REQ-010 cfg_we  input  1  configuration write strobe.
REQ-011 cfg_chan  input  clog2(CHANNELS) (min 1)  channel being written.
REQ-012 cfg_step  input  ACC_WIDTH  phase increment per slot.
REQ-013 cfg_phase  input  ACC_WIDTH  phase offset.
REQ-014 cfg_gain  input  4  attenuation, arithmetic right shift 0..15.
REQ-015 cfg_clear  input  1  with cfg_we: zero the channel accumulator.
REQ-016 sample_out  output  OUT_WIDTH  signed sample.
REQ-017 sample_chan  output  clog2(CHANNELS) (min 1)  channel of sample_out.
REQ-018 sample_valid  output  1  one-cycle qualifier for sample_out/sample_chan.
REQ-019 frame_end  output  1  high with sample_valid when sample_chan = CHANNELS-1.

Function
REQ-020 SHALL hold per channel: acc, step, phase, gain registers.
REQ-021 SHALL keep slot counter slot; enable high: slot advances modulo CHANNELS, wraps CHANNELS-1 -> 0.
REQ-022 Slot cycle (enable high): addr = (acc[slot] + phase[slot]) mod 2^ACC_WIDTH, bits [ACC_WIDTH-1:FPBITS]; acc[slot] <= acc[slot] + step[slot], wrap modulo 2^ACC_WIDTH, no saturation.
REQ-023 Address SHALL use pre-update accumulator value.
REQ-024 Internal ROM, 2^ROM_ADDR_BITS entries: entry k = round((2^(OUT_WIDTH-1)-1) * sin(2*pi*k/2^ROM_ADDR_BITS)), two's complement.
REQ-025 Pipeline: stage 1 registers addr/slot/gain; stage 2 registers ROM word; stage 3 registers (ROM word >>> gain), sign-extended.
REQ-026 Slot in cycle N SHALL produce sample_valid high in cycle N+3; full throughput, one sample per enabled cycle.
REQ-027 enable low: slot and accumulators hold; in-flight samples still drain; sample_valid low for the bubble.
REQ-028 cfg_we: step, phase, gain of cfg_chan load at clock edge; effective from next slot of that channel.
REQ-029 cfg_we in same cycle as that channel's slot: slot uses old step/phase/gain; acc update uses old step.
REQ-030 cfg_we with cfg_clear: acc[cfg_chan] <= 0, overriding same-cycle slot update.
REQ-031 cfg_chan >= CHANNELS SHALL be ignored.
REQ-032 frame_end = sample_valid AND (sample_chan = CHANNELS-1).

Reset
REQ-033 reset high: all acc, step, phase, gain = 0; slot = 0; pipeline valids cleared.
REQ-034 Outputs in cycle after reset edge: sample_out = 0, sample_chan = 0, sample_valid = 0, frame_end = 0.
REQ-035 Reset mid-operation SHALL discard in-flight samples; reset dominates enable and cfg_we.

Verification
REQ-036 Reset, enable high, all config zero -> sample_valid from cycle 3; chan 0,1,2,3 repeat; sample_out = 0; frame_end each 4th valid.
REQ-037 ch0 step 0x10000, others 0 -> ch0 samples ROM[0], ROM[1], ROM[2]...; ROM[256] = 32767 on 257th ch0 sample, ROM[768] = -32767 on 769th.
REQ-038 ch1 phase 0x1000000, step 0, gain 2 -> every ch1 sample = 32767 >>> 2 = 8191.
REQ-039 ch0 step 0x3FFFFFF (-1 LSB modulo) -> acc wraps 0 -> 0x3FFFFFF; address 1023 on second ch0 sample; no glitch.
REQ-040 cfg_we to ch2 in ch2 slot cycle -> that sample uses old config, next ch2 sample uses new; cfg_clear same cycle -> next ch2 address 0.
REQ-041 Reset asserted with 3 samples in flight -> no sample_valid until 3 cycles after enable resumes; first sample chan 0, value 0.
